wb_sequencer: RTL and testbench

- Upstream command stage for the single-transfer Wishbone master control block.
- Accepts a block command (direction, start word address, length), then issues one single READ or WRITE transfer per word through that block's `read_i`/`write_i`/`done_o`/`fail_o`/`busy_o` interface.
- Streams write data in and read data out over valid/ready handshakes; retries failed words and times out hung transfers.

---
 rtl/wb_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_wb_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Block command sequencer: one READ/WRITE transfer per word, with retry and timeout.
// Outputs registered; one transfer in flight; write data stalls in FETCH, read data holds in DRAIN.
module wb_sequencer #(
  parameter int unsigned ADDR    = 24,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CBITS   = 8,
  parameter int unsigned RETRY   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DELAY   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             write_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [CBITS-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             xfer_read_o,
  output logic             xfer_write_o,
  input  logic             xfer_busy_i,
  input  logic             xfer_done_i,
  input  logic             xfer_fail_i,
  output logic [ADDR-1:0]  adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic [WIDTH-1:0] dat_i
);

  localparam int unsigned RW = (RETRY > 0) ? $clog2(RETRY + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // DELAY only shapes behavioural models; the synthesizable registers carry no delay.
  if (DELAY > 32'd1000000) begin : g_delay_range
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [ADDR-1:0]  adr_q, adr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] mdat_q, mdat_d;
  logic [CBITS-1:0] rem_q, rem_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             xrd_q, xrd_d;
  logic             xwr_q, xwr_d;
  logic             tmo_hit;

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      mdat_q  <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      xrd_q   <= 1'b0;
      xwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      mdat_q  <= mdat_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      xrd_q   <= xrd_d;
      xwr_q   <= xwr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    mdat_d  = mdat_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    xrd_d   = 1'b0;
    xwr_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          adr_d   = addr_i;
          rem_d   = len_i;
          dir_d   = write_i;
          retry_d = '0;
          busy_d  = 1'b1;
          state_d = write_i ? S_FETCH : S_ISSUE;
        end
      end
      S_FETCH: begin
        if (s_valid_i) begin
          dat_d   = s_data_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!xfer_busy_i) begin
          xwr_d   = dir_q;
          xrd_d   = !dir_q;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // done takes priority over a simultaneous fail or timeout
        if (xfer_done_i) begin
          if (!dir_q) begin
            mdat_d  = dat_i;
            state_d = S_DRAIN;
          end else if (rem_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            adr_d   = adr_q + ADDR'(1);
            rem_d   = rem_q - CBITS'(1);
            retry_d = '0;
            state_d = S_FETCH;
          end
        end else if (xfer_fail_i || tmo_hit) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_ISSUE;
          end else begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (m_ready_i) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            adr_d   = adr_q + ADDR'(1);
            rem_d   = rem_q - CBITS'(1);
            retry_d = '0;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign s_ready_o    = (state_q == S_FETCH);
  assign m_valid_o    = (state_q == S_DRAIN);
  assign m_data_o     = mdat_q;
  assign xfer_read_o  = xrd_q;
  assign xfer_write_o = xwr_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomized bench for wb_sequencer: a scripted transfer engine plus a word/attempt-level reference model.
module tb_wb_sequencer;

  localparam int ADDR    = 24;
  localparam int WIDTH   = 32;
  localparam int CBITS   = 8;
  localparam int RETRY   = 2;
  localparam int TIMEOUT = 4;

  logic             clk_i;
  logic             rst_ni;
  logic             start_i;
  logic             write_i;
  logic [ADDR-1:0]  addr_i;
  logic [CBITS-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic             fail_o;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [WIDTH-1:0] s_data_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             xfer_read_o;
  logic             xfer_write_o;
  logic             xfer_busy_i;
  logic             xfer_done_i;
  logic             xfer_fail_i;
  logic [ADDR-1:0]  adr_o;
  logic [WIDTH-1:0] dat_o;
  logic [WIDTH-1:0] dat_i;

  wb_sequencer #(
    .ADDR(ADDR), .WIDTH(WIDTH), .CBITS(CBITS), .RETRY(RETRY), .TIMEOUT(TIMEOUT), .DELAY(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .write_i(write_i), .addr_i(addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_data_i(s_data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .xfer_read_o(xfer_read_o), .xfer_write_o(xfer_write_o),
    .xfer_busy_i(xfer_busy_i), .xfer_done_i(xfer_done_i), .xfer_fail_i(xfer_fail_i),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit               w;
    logic [ADDR-1:0]  a;
    logic [WIDTH-1:0] d;
  } req_t;

  // engine outcome per attempt: 0 done, 1 fail, 2 silent (timeout), 3 done and fail together
  int               plan_oc[$];
  int               plan_d[$];
  logic [WIDTH-1:0] plan_dat[$];
  logic [WIDTH-1:0] wdata[$];

  int busy_pct, mr_pct, sv_pct, mr_block, rst_at_req;
  bit sv_alt;
  int n_total, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, busy_o, 0);
    check({p, "_done"}, done_o, 0);
    check({p, "_fail"}, fail_o, 0);
    check({p, "_s_ready"}, s_ready_o, 0);
    check({p, "_m_valid"}, m_valid_o, 0);
    check({p, "_xfer_read"}, xfer_read_o, 0);
    check({p, "_xfer_write"}, xfer_write_o, 0);
    check({p, "_adr"}, adr_o, 0);
    check({p, "_dat"}, dat_o, 0);
    check({p, "_m_data"}, m_data_o, 0);
  endtask

  task automatic quiet_inputs();
    start_i = 0; write_i = 0; addr_i = '0; len_i = '0;
    s_valid_i = 0; s_data_i = '0; m_ready_i = 0;
    xfer_busy_i = 0; xfer_done_i = 0; xfer_fail_i = 0; dat_i = '0;
  endtask

  task automatic clear_plan();
    plan_oc.delete(); plan_d.delete(); plan_dat.delete(); wdata.delete();
  endtask

  task automatic push_plan(input int oc, input int d, input logic [WIDTH-1:0] dat);
    plan_oc.push_back(oc); plan_d.push_back(d); plan_dat.push_back(dat);
  endtask

  task automatic rand_plan(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(99);
      push_plan((r < 75) ? 0 : (r < 87) ? 1 : (r < 94) ? 2 : 3, $urandom_range(3), $urandom);
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [ADDR-1:0] a, input int ln);
    req_t             exp_q[$];
    logic [WIDTH-1:0] rd_q[$];
    req_t             e;
    bit               ok, got, pend, prev_hold, prev_busy, finished;
    int               p, tries, oc, pidx, cd, cur_oc, last_oc, last_req_cyc, npulse, ws, blk, budget;
    logic [WIDTH-1:0] held, cur_dat;

    // reference: walk words and attempts in order, consuming one planned outcome per issue
    ok = 1; p = 0;
    for (int w = 0; w <= ln && ok; w++) begin
      tries = 0; got = 0;
      while (!got && ok) begin
        e.w = wr; e.a = a + ADDR'(w); e.d = wr ? wdata[w] : '0;
        exp_q.push_back(e);
        oc = (p < plan_oc.size()) ? plan_oc[p] : 0;
        if (oc == 0 || oc == 3) begin
          got = 1;
          if (!wr) rd_q.push_back(plan_dat[p]);
        end else begin
          tries++;
          if (tries > RETRY) ok = 0;
        end
        p++;
      end
    end

    @(negedge clk_i);
    quiet_inputs();
    start_i = 1; write_i = wr; addr_i = a; len_i = CBITS'(ln);
    @(posedge clk_i);
    pend = 0; prev_hold = 0; prev_busy = 0; finished = 0; held = '0; cur_dat = '0;
    pidx = 0; cd = 0; cur_oc = 0; last_oc = -1; last_req_cyc = 0; npulse = 0; ws = 0; blk = 0;
    budget = (ln + 1) * (RETRY + 1) * 40 + 50;

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk_i);
      if (cyc == 0) check("busy_set", busy_o, 1);
      if (xfer_read_o || xfer_write_o) begin
        npulse++;
        check("req_single", xfer_read_o & xfer_write_o, 0);
        check("req_busy_gate", prev_busy, 0);
        check("req_outstanding", pend, 0);
        check("req_in_drain", m_valid_o, 0);
        if (last_oc == 2 && busy_pct == 0) check("tmo_gap", cyc - last_req_cyc, TIMEOUT + 1);
        if (exp_q.size() == 0) check("req_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("req_kind", xfer_write_o, e.w);
          check("req_adr", adr_o, e.a);
          if (e.w) check("req_dat", dat_o, e.d);
        end
        cur_oc  = (pidx < plan_oc.size()) ? plan_oc[pidx] : 0;
        cd      = ((pidx < plan_d.size()) ? plan_d[pidx] : 0) + 1;
        cur_dat = (pidx < plan_dat.size()) ? plan_dat[pidx] : '0;
        pidx++;
        pend = (cur_oc != 2);
        last_oc = cur_oc; last_req_cyc = cyc;
        if (rst_at_req != 0 && npulse == rst_at_req) begin
          #2 rst_ni = 0;
          #1 check_zero("rst_async");
          quiet_inputs();
          repeat (3) begin
            @(negedge clk_i);
            check("rst_no_end", {done_o, fail_o}, 0);
          end
          rst_ni = 1;
          return;
        end
      end
      if (prev_hold) begin
        check("m_valid_hold", m_valid_o, 1);
        check("m_data_hold", m_data_o, held);
      end
      if (done_o || fail_o) begin
        check("end_both", done_o & fail_o, 0);
        check("end_done", done_o, ok);
        check("end_busy", busy_o, 0);
        check("end_reqs_left", exp_q.size(), 0);
        check("end_reads_left", rd_q.size(), 0);
        if (fail_o && last_oc == 2) check("tmo_abort_gap", cyc - last_req_cyc, TIMEOUT);
        finished = 1;
        break;
      end

      xfer_done_i = 0; xfer_fail_i = 0; dat_i = $urandom;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 0;
          xfer_done_i = (cur_oc == 0 || cur_oc == 3);
          xfer_fail_i = (cur_oc == 1 || cur_oc == 3);
          dat_i = cur_dat;
        end
      end
      xfer_busy_i = ($urandom_range(99) < busy_pct);
      prev_busy = xfer_busy_i;

      if (s_ready_o) begin
        if (!wr) check("s_ready_on_read", 1, 0);
        s_valid_i = sv_alt ? !s_valid_i : ($urandom_range(99) < sv_pct);
        if (s_valid_i && ws <= ln) begin
          s_data_i = wdata[ws];
          ws++;
        end else begin
          if (s_valid_i) check("s_extra", 1, 0);
          s_data_i = $urandom;
        end
      end else begin
        s_valid_i = $urandom_range(1);
        s_data_i = $urandom;
      end

      if (m_valid_o) begin
        if (blk < mr_block) begin
          m_ready_i = 0;
          blk++;
        end else m_ready_i = ($urandom_range(99) < mr_pct);
        if (m_ready_i) begin
          if (rd_q.size() == 0) check("m_extra", 1, 0);
          else check("m_data", m_data_o, rd_q.pop_front());
        end
        prev_hold = !m_ready_i;
        held = m_data_o;
      end else begin
        m_ready_i = $urandom_range(1);
        prev_hold = 0;
      end

      // stray commands while busy must be ignored
      start_i = ($urandom_range(7) == 0);
      write_i = $urandom_range(1);
      addr_i  = $urandom;
      len_i   = $urandom;
    end

    quiet_inputs();
    if (!finished) check("cmd_budget", 0, 1);
    @(negedge clk_i);
    check("end_pulse_once", {done_o, fail_o}, 0);
    check("idle_busy", busy_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0;
    busy_pct = 0; mr_pct = 100; sv_pct = 100; sv_alt = 0; mr_block = 0; rst_at_req = 0;
    quiet_inputs();
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1;

    // single read
    clear_plan(); push_plan(0, 1, 32'hDEADBEEF);
    run_cmd(0, 24'h000010, 0);

    // 4-word write across the address wrap, gapped write data
    clear_plan(); wdata = {32'd1, 32'd2, 32'd3, 32'd4};
    repeat (4) push_plan(0, 1, '0);
    sv_alt = 1; run_cmd(1, 24'hFFFFFE, 3); sv_alt = 0;

    // read backpressure on the first word
    clear_plan(); rand_plan(0); push_plan(0, 0, 32'h11111111); push_plan(0, 1, 32'h22222222); push_plan(0, 2, 32'h33333333);
    mr_block = 5; run_cmd(0, 24'h000100, 2); mr_block = 0;

    // two fails then success, then three fails and abort
    clear_plan(); push_plan(1, 0, '0); push_plan(1, 2, '0); push_plan(0, 1, 32'hCAFEF00D);
    run_cmd(0, 24'h000200, 0);
    clear_plan(); wdata = {32'hA5A5A5A5, 32'h5A5A5A5A};
    push_plan(0, 1, '0); push_plan(1, 1, '0); push_plan(1, 0, '0); push_plan(1, 3, '0);
    run_cmd(1, 24'h000300, 1);

    // timeout re-issue, then timeout abort
    clear_plan(); push_plan(2, 0, '0); push_plan(0, 2, 32'h0BADF00D);
    run_cmd(0, 24'h000400, 0);
    clear_plan(); push_plan(2, 0, '0); push_plan(2, 0, '0); push_plan(2, 0, '0);
    run_cmd(0, 24'h000500, 0);

    // done and fail in the same cycle
    clear_plan(); wdata = {32'h12345678}; push_plan(3, 1, '0);
    run_cmd(1, 24'h000600, 0);

    // heavy engine-busy gating
    clear_plan(); wdata = {32'h1, 32'h2, 32'h3}; rand_plan(9);
    busy_pct = 70; run_cmd(1, 24'h000700, 2); busy_pct = 0;

    // reset while waiting on word 2, then a normal command
    clear_plan(); wdata = {32'h10, 32'h20, 32'h30, 32'h40}; repeat (4) push_plan(0, 2, '0);
    rst_at_req = 2; run_cmd(1, 24'h000800, 3); rst_at_req = 0;
    clear_plan(); rand_plan(6);
    run_cmd(0, 24'h000900, 1);

    // maximum length, wrapping address
    clear_plan(); rand_plan(256 * (RETRY + 1));
    run_cmd(0, 24'hFFFF80, 255);

    // randomized commands
    for (int t = 0; t < 30; t++) begin
      int ln;
      logic [ADDR-1:0] a;
      ln = $urandom_range(7);
      a = ($urandom_range(3) == 0) ? (24'hFFFFF0 + ADDR'($urandom_range(15))) : ADDR'($urandom);
      clear_plan();
      for (int i = 0; i <= ln; i++) wdata.push_back($urandom);
      rand_plan((ln + 1) * (RETRY + 1));
      busy_pct = $urandom_range(50);
      mr_pct = $urandom_range(100, 30);
      sv_pct = $urandom_range(100, 30);
      run_cmd($urandom_range(1), a, ln);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
